// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, iteration count and FSM encoding for the mul/div unit
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  localparam int ITER_COUNT = 32;

endpackage

// File: rtl/mdu_sign_fix.sv
// rtl/mdu_sign_fix.sv - combinational operand abs and result negation for the mul/div unit
module mdu_sign_fix (
  input  logic        signed_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] abs_a_o,
  output logic [31:0] abs_b_o,
  input  logic [63:0] res_i,
  input  logic        neg_all_i,
  input  logic        neg_hi_i,
  input  logic        neg_lo_i,
  output logic [63:0] res_o
);

  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign abs_a_o = (signed_i && a_i[31]) ? (~a_i + 32'd1) : a_i;
  assign abs_b_o = (signed_i && b_i[31]) ? (~b_i + 32'd1) : b_i;

  // Divide negates remainder and quotient independently; multiply negates the full product.
  assign res_hi = neg_hi_i ? (~res_i[63:32] + 32'd1) : res_i[63:32];
  assign res_lo = neg_lo_i ? (~res_i[31:0] + 32'd1) : res_i[31:0];
  assign res_o  = neg_all_i ? (~res_i + 64'd1) : {res_hi, res_lo};

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  logic [31:0] a_q, a_d;
  logic        div_q, div_d;
  logic        neg_res_q, neg_res_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        op_signed;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [63:0] fixed_res;
  logic [32:0] mul_sum;
  logic [32:0] rem_sh;
  logic [63:0] mul_step;
  logic [63:0] div_step;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);

  mdu_sign_fix u_sign_fix (
    .signed_i  (op_signed),
    .a_i       (a),
    .b_i       (b),
    .abs_a_o   (abs_a),
    .abs_b_o   (abs_b),
    .res_i     (acc_q),
    .neg_all_i (~div_q & neg_res_q),
    .neg_hi_i  (div_q & neg_rem_q),
    .neg_lo_i  (div_q & neg_res_q),
    .res_o     (fixed_res)
  );

  // acc holds {partial product high, multiplier} or {remainder, dividend/quotient}.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_step = {mul_sum, acc_q[31:1]};

  assign rem_sh   = {acc_q[63:32], acc_q[31]};
  always_comb begin
    div_step = {rem_sh[31:0], acc_q[30:0], 1'b0};
    if (rem_sh >= {1'b0, b_q}) begin
      div_step = {32'(rem_sh - {1'b0, b_q}), acc_q[30:0], 1'b1};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    a_d       = a_q;
    div_d     = div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = 6'd0;
          acc_d     = {32'd0, abs_a};
          b_d       = abs_b;
          a_d       = a;
          div_d     = op[1];
          neg_res_d = op_signed & (a[31] ^ b[31]);
          neg_rem_d = op_signed & a[31];
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        acc_d = div_q ? div_step : mul_step;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(ITER_COUNT - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        // Divide by zero reports the untouched dividend regardless of sign handling.
        if (div_q && (b_q == 32'd0)) begin
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = fixed_res[63:32];
          lo_d = fixed_res[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      acc_q     <= 64'd0;
      b_q       <= 32'd0;
      a_q       <= 32'd0;
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      a_q       <= a_d;
      div_q     <= div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge; start is sampled at the next edge (N).
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int intrude_at = -1);
    int          cyc;
    logic        busy_ok;
    logic        hold_ok;
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0 = hi;
    lo0 = lo;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    busy_ok = busy;
    hold_ok = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin
      if (hi !== hi0 || lo !== lo0) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (!done && !busy) busy_ok = 1'b0;
      if (cyc == intrude_at) begin
        start = 1'b1;
        op = OP_DIVU;
        a = 32'd1;
        b = 32'd1;
        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1111_1111;
      end else if (cyc == intrude_at + 1) begin
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
      end
    end
    check({tag, " latency"}, 64'(cyc), 64'd33);
    check({tag, " busy_during"}, {63'd0, busy_ok}, 64'd1);
    check({tag, " hilo_hold"}, {63'd0, hold_ok}, 64'd1);
    check({tag, " busy_at_done"}, {63'd0, busy}, 64'd0);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    @(posedge clk);
    #1;
    check({tag, " done_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int          cyc;
    logic        hold_ok;
    logic        seen;

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;

    run_op("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_neg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_by0", OP_DIVU, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_by0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);

    hi_we = 1'b1;
    wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    check("mthi", {hi, lo}, {32'h1234_5678, 32'hFFFF_FFFF});
    lo_we = 1'b1;
    wdata = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    lo_we = 1'b0;
    check("mtlo", {hi, lo}, {32'h1234_5678, 32'h9ABC_DEF0});

    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hDEAD_BEEF;
    run_op("start_drops_write", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    run_op("start_while_busy", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 10);

    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op = OP_MULTU;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hold_ok = 1'b1;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 10) begin
        start = 1'b1;
        hi_we = 1'b1;
        op = OP_DIVU;
        wdata = 32'h2222_2222;
      end else begin
        start = 1'b0;
        hi_we = 1'b0;
      end
      if (hi !== 32'hA5A5_A5A5 || lo !== 32'hA5A5_A5A5 || !busy || done) hold_ok = 1'b0;
    end
    check("abort hold_in_calc", {63'd0, hold_ok}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort async busy", {63'd0, busy}, 64'd0);
    check("abort async hilo", {hi, lo}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy || hi !== 32'd0 || lo !== 32'd0) seen = 1'b1;
    end
    check("abort no_done_no_op", {63'd0, seen}, 64'd0);

    run_op("after_abort", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand, HI and LO width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin an operation.
REQ-005 SHALL have port op, input, 2, the operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port a, input, 32, multiplicand or dividend.
REQ-007 SHALL have port b, input, 32, multiplier or divisor.
REQ-008 SHALL have port hi_we, input, 1, the MTHI write strobe.
REQ-009 SHALL have port lo_we, input, 1, the MTLO write strobe.
REQ-010 SHALL have port wdata, input, 32, the MTHI/MTLO write data.
REQ-011 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-012 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-013 SHALL have port hi, output, 32, the HI register: product[63:32] or remainder.
REQ-014 SHALL have port lo, output, 32, the LO register: product[31:0] or quotient.

Function
REQ-015 SHALL implement the FSM states IDLE, CALC and FIX; busy SHALL be high exactly when the state is not IDLE.
REQ-016 In IDLE, start=1 SHALL latch op, a and b and move the FSM to CALC.
REQ-017 In IDLE, start=1 SHALL clear the iteration counter to 0.
REQ-018 For signed ops, a and b SHALL be latched as absolute values, and the result signs SHALL be recorded.
REQ-019 CALC SHALL run exactly 32 cycles, one radix-2 step per cycle, then move to FIX.
- Multiply: shift-add.
- Divide: restoring shift-subtract.
REQ-020 FIX SHALL apply the sign correction and write HI/LO, then return to IDLE.
- Signed multiply: negate the 64-bit product if the operand signs differ.
- Signed divide: quotient is negative if the signs differ; remainder takes the dividend's sign.
REQ-021 Latency: if start is sampled at edge N, HI/LO SHALL update at edge N+33, and done SHALL be high for the single cycle following edge N+33.
REQ-022 busy SHALL be high during the cycles after edges N through N+32.
REQ-023 A start asserted while busy SHALL be ignored, with no queuing.
REQ-024 Divide by zero (b=0, DIV or DIVU) SHALL keep the same 33-cycle latency.
REQ-025 Divide by zero SHALL produce HI=a (the original dividend) and LO=32'hFFFFFFFF.
REQ-026 DIV 32'h80000000 / 32'hFFFFFFFF SHALL produce LO=32'h80000000 and HI=0, with no trap.
REQ-027 hi_we or lo_we in IDLE, with start=0, SHALL write wdata into HI or LO at the next edge.
REQ-028 hi_we and lo_we SHALL be ignored while busy.
REQ-029 A start asserted together with hi_we or lo_we in IDLE SHALL begin the operation and drop the write.
REQ-030 HI/LO SHALL hold their values between updates and SHALL NOT change during CALC.

Reset
REQ-031 rst_n=0 SHALL, asynchronously: set the state to IDLE, and force busy=0, done=0, hi=0, lo=0.
REQ-032 rst_n=0 SHALL also clear the counter and all datapath registers.
REQ-033 Reset during CALC or FIX SHALL abort the operation, with no done pulse and HI/LO cleared.
REQ-034 After reset release, the first rising edge SHALL accept start normally.

Structure
REQ-035 Shared package mdu_pkg SHALL hold the op codes, ITER_COUNT=32, and the FSM state encoding.
REQ-036 Sub-module mdu_sign_fix SHALL perform the combinational abs/negate (32- and 64-bit) used at latch and in FIX.
REQ-037 The counter SHALL be 6 bits; the partial result register SHALL be 64 bits, combined {remainder, quotient/product-low}.

Verification
REQ-038 MULT a=32'hFFFFFFFD b=5 -> done at start+33 with hi=32'hFFFFFFFF, lo=32'hFFFFFFF1.
REQ-039 MULTU a=b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
REQ-040 DIV a=32'hFFFFFFF9 (-7) b=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
REQ-040 also: DIV a=32'h80000000 b=32'hFFFFFFFF -> lo=32'h80000000, hi=0.
REQ-041 DIVU a=100 b=0 -> hi=32'h00000064, lo=32'hFFFFFFFF, latency 33.
REQ-042 Start MULTU, assert start and hi_we at cycle 10, assert rst_n=0 at cycle 20, then check three results:
- No second operation starts.
- HI is unchanged during CALC.
- After reset: busy=0, hi=lo=0, and no done pulse.
